// File: rtl/input_csr.sv
// Console input CSR: a host pushes bytes into a small FIFO and the CPU
// polls/pops them through one CSR on the KCP53K CSR bus.
module input_csr #(
  parameter logic [11:0] CSR_ADDR   = 12'h0FE,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [11:0] cadr_i,
  output logic        cvalid_o,
  output logic [63:0] cdat_o,
  input  logic [63:0] cdat_i,
  input  logic        coe_i,
  input  logic        cwe_i,
  input  logic [7:0]  host_dat_i,
  input  logic        host_stb_i,
  output logic        host_ack_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overrun_q, overrun_d;

  logic       sel, avail, full;
  logic       flush, clr, pop, push, ovf;
  logic [7:0] head;
  logic       unused_cdat;

  assign unused_cdat = ^cdat_i[63:2];

  always_comb begin
    sel   = (cadr_i == CSR_ADDR);
    avail = (count_q != '0);
    full  = (count_q == CNT_W'(DEPTH));
    head  = avail ? mem_q[rd_ptr_q] : 8'h00;

    flush = sel & cwe_i & cdat_i[1];
    clr   = sel & cwe_i & cdat_i[0];
    pop   = sel & coe_i & avail & ~flush;
    // Acceptance uses pre-edge FULL, so a same-edge pop never frees room.
    push  = host_stb_i & ~full & ~flush;
    ovf   = host_stb_i & full;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Set has priority over clear when both land on the same edge.
    if (ovf)      overrun_d = 1'b1;
    else if (clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte storage carries no reset; AVAIL masks stale contents on read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= host_dat_i;
  end

  always_comb begin
    cvalid_o   = sel;
    host_ack_o = ~full;
    cdat_o     = '0;
    if (sel) cdat_o = {52'b0, avail, head, overrun_q, full, 1'b0};
  end

endmodule

// File: tb/tb_input_csr.sv
// Directed bench for input_csr: host pushes, CPU pops, full/overrun,
// clear, flush and simultaneous push/pop, with hand-computed read values.
module tb_input_csr;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [11:0] cadr_i;
  logic        cvalid_o;
  logic [63:0] cdat_o;
  logic [63:0] cdat_i;
  logic        coe_i;
  logic        cwe_i;
  logic [7:0]  host_dat_i;
  logic        host_stb_i;
  logic        host_ack_o;

  int vectors = 0;
  int miscompares = 0;

  input_csr #(.CSR_ADDR(12'h0FE), .DEPTH_LOG2(2)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .cadr_i(cadr_i), .cvalid_o(cvalid_o),
    .cdat_o(cdat_o), .cdat_i(cdat_i), .coe_i(coe_i), .cwe_i(cwe_i),
    .host_dat_i(host_dat_i), .host_stb_i(host_stb_i), .host_ack_o(host_ack_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    host_stb_i = 1'b1;
    host_dat_i = b;
    step();
    host_stb_i = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0; cadr_i = 12'h0FE; cdat_i = '0; coe_i = 1'b0; cwe_i = 1'b0;
    host_dat_i = '0; host_stb_i = 1'b0;
    #2;
    check("reset_cdat", cdat_o, 64'h0);
    check("reset_ack", {63'b0, host_ack_o}, 64'h1);
    check("reset_cvalid", {63'b0, cvalid_o}, 64'h1);
    step();
    reset_ni = 1'b1;
    step();

    // Async reset with three bytes queued
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    #1;
    check("pre_reset_head", cdat_o, 64'hD08);
    #1;
    reset_ni = 1'b0;
    #1;
    check("midreset_cdat", cdat_o, 64'h0);
    check("midreset_ack", {63'b0, host_ack_o}, 64'h1);
    step();
    reset_ni = 1'b1;
    step();
    check("post_reset_empty", cdat_o, 64'h0);

    // Basic push and pop
    push_byte(8'h41); push_byte(8'h42);
    coe_i = 1'b1;
    #1; check("pop1", cdat_o, 64'hA08);
    step(); check("pop2", cdat_o, 64'hA10);
    step(); check("pop3_empty", cdat_o, 64'h0);
    coe_i = 1'b0;

    // Non-popping reads and deselected address
    push_byte(8'h41);
    #1; check("peek1", cdat_o, 64'hA08);
    step(); check("peek2", cdat_o, 64'hA08);
    cadr_i = 12'h0FF; coe_i = 1'b1;
    #1;
    check("desel_cvalid", {63'b0, cvalid_o}, 64'h0);
    check("desel_cdat", cdat_o, 64'h0);
    step();
    cadr_i = 12'h0FE; coe_i = 1'b0;
    #1; check("desel_no_pop", cdat_o, 64'hA08);
    coe_i = 1'b1; step(); coe_i = 1'b0;
    check("drained", cdat_o, 64'h0);

    // Fill to full, overflow, drain in order
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    #1;
    check("full_read", cdat_o, 64'h80A);
    check("full_ack", {63'b0, host_ack_o}, 64'h0);
    push_byte(8'h05);
    check("overrun_set", cdat_o, 64'h80E);
    coe_i = 1'b1;
    #1; check("drain01", cdat_o, 64'h80E);
    step(); check("drain02", cdat_o, 64'h814);
    step(); check("drain03", cdat_o, 64'h81C);
    step(); check("drain04", cdat_o, 64'h824);
    step(); check("drain_empty", cdat_o, 64'h4);
    coe_i = 1'b0;

    // Clear overrun; then clear racing an overflow
    cwe_i = 1'b1; cdat_i = 64'h1;
    #1; check("clr_preedge", cdat_o, 64'h4);
    step(); cwe_i = 1'b0; cdat_i = '0;
    check("clr_done", cdat_o, 64'h0);
    push_byte(8'h11); push_byte(8'h12); push_byte(8'h13); push_byte(8'h14);
    cwe_i = 1'b1; cdat_i = 64'h1;
    push_byte(8'h15);
    cwe_i = 1'b0; cdat_i = '0;
    check("ovf_beats_clr", cdat_o, 64'h88E);
    check("ovf_ack", {63'b0, host_ack_o}, 64'h0);

    // Flush with three queued and a concurrent strobe
    coe_i = 1'b1; step(); coe_i = 1'b0;
    check("three_left", cdat_o, 64'h894);
    cwe_i = 1'b1; cdat_i = 64'h2;
    #1; check("flush_preedge", cdat_o, 64'h894);
    push_byte(8'h77);
    cwe_i = 1'b0; cdat_i = '0;
    check("flush_done", cdat_o, 64'h4);
    cwe_i = 1'b1; cdat_i = 64'h1; step(); cwe_i = 1'b0; cdat_i = '0;
    check("flush_clr", cdat_o, 64'h0);

    // Simultaneous push and pop at count 2
    push_byte(8'h21); push_byte(8'h22);
    coe_i = 1'b1;
    #1; check("pp_head", cdat_o, 64'h908);
    push_byte(8'h23);
    check("pp_next", cdat_o, 64'h910);
    step(); check("pp_last", cdat_o, 64'h918);
    step(); check("pp_empty", cdat_o, 64'h0);
    coe_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
